// File: rtl/ram_data_arbiter.sv
// ram_data_arbiter: two-master round-robin arbiter in front of the single
// data port of the on-chip ram. Responses are routed back in grant order
// through a small FIFO of master IDs. The block also keeps a saturating
// contention counter and a sticky flag for responses nobody asked for.
module ram_data_arbiter #(
  parameter int ADDR_WIDTH      = 22,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [15:0]           conflict_cnt_o,
  output logic                  err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] C_MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  // FIFO pointer advance with explicit wrap (depth is a power of two, but
  // a depth of 1 still needs a 1-bit pointer that stays at slot 0).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == C_LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic            r_prio;
  logic [CW-1:0]   r_cnt;
  logic            r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [15:0]     r_conflict_cnt;
  logic            r_err;

  logic            w_full;
  logic            w_winner;
  logic            w_mem_req;
  logic            w_hs;
  logic            w_head;
  logic            w_pop;
  logic            w_spurious;
  logic            w_contend;

  assign w_full     = (r_cnt == C_MAX_CNT);
  assign w_mem_req  = (m0_req_i | m1_req_i) & ~w_full & ~rst_i;
  assign w_hs       = w_mem_req & mem_gnt_i;
  assign w_head     = r_fifo[r_rptr];
  assign w_pop      = mem_rvalid_i & (r_cnt != {CW{1'b0}}) & ~rst_i;
  assign w_spurious = mem_rvalid_i & (r_cnt == {CW{1'b0}}) & ~rst_i;
  assign w_contend  = m0_req_i & m1_req_i & ~w_full;

  // Winner selection: a lone requester wins, contention goes to r_prio.
  always_comb begin
    w_winner = 1'b0;
    if (m0_req_i && m1_req_i) begin
      w_winner = r_prio;
    end else if (m1_req_i) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
  end

  // Memory-side request fields follow the winner even when idle.
  always_comb begin
    mem_req_o   = w_mem_req;
    mem_addr_o  = m0_addr_i;
    mem_we_o    = m0_we_i;
    mem_be_o    = m0_be_i;
    mem_wdata_o = m0_wdata_i;
    if (w_winner) begin
      mem_addr_o  = m1_addr_i;
      mem_we_o    = m1_we_i;
      mem_be_o    = m1_be_i;
      mem_wdata_o = m1_wdata_i;
    end else begin
      mem_addr_o  = m0_addr_i;
      mem_we_o    = m0_we_i;
      mem_be_o    = m0_be_i;
      mem_wdata_o = m0_wdata_i;
    end
  end

  assign m0_gnt_o       = w_hs & ~w_winner;
  assign m1_gnt_o       = w_hs & w_winner;
  assign m0_rvalid_o    = w_pop & ~w_head;
  assign m1_rvalid_o    = w_pop & w_head;
  assign m0_rdata_o     = mem_rdata_i;
  assign m1_rdata_o     = mem_rdata_i;
  assign conflict_cnt_o = r_conflict_cnt;
  assign err_o          = r_err;

  // ID FIFO storage: records which master owns each accepted transaction.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_fifo[r_wptr] <= w_winner;
    end
  end

  // Control state: priority, occupancy, pointers, contention count, error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio         <= 1'b0;
      r_cnt          <= {CW{1'b0}};
      r_wptr         <= {PW{1'b0}};
      r_rptr         <= {PW{1'b0}};
      r_conflict_cnt <= 16'h0000;
      r_err          <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wptr <= ptr_inc(r_wptr);
        r_prio <= ~w_winner;
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_contend && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
      if (w_spurious) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Directed self-checking bench for ram_data_arbiter with a same-cycle-grant
// ram model (rvalid one cycle after grant) plus manual response driving.
module tb_ram_data_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [21:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req_o, mem_we_o;
  logic [21:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [15:0] conflict_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Memory model and manual response controls
  logic [31:0] ram [0:1023];
  logic        mdl_init, use_model, mdl_rv, man_rvalid;
  logic [31:0] mdl_rdata, man_rdata;

  always #5 clk = ~clk;

  ram_data_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .conflict_cnt_o(conflict_cnt), .err_o(err)
  );

  assign mem_rvalid_i = use_model ? mdl_rv : man_rvalid;
  assign mem_rdata_i  = use_model ? mdl_rdata : man_rdata;

  // ram behaviour: accept on req&gnt, answer one cycle later
  always @(posedge clk) begin
    if (mdl_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA000_0000 | i;
      mdl_rv <= 1'b0;
    end else if (use_model && mem_req_o && mem_gnt_i) begin
      mdl_rv    <= 1'b1;
      mdl_rdata <= ram[mem_addr_o[11:2]];
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end else begin
      mdl_rv <= 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0; man_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle();
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; use_model = 1'b0; mem_gnt_i = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; man_rvalid = 1'b1;
    m0_we = 1'b0; m1_we = 1'b0;
    cyc();
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req_o); end
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {m0_gnt, m1_gnt}); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
    rst_i = 1'b0; man_rvalid = 1'b0;
    #1;
    checks++; if (conflict_cnt !== 16'h0000) begin errors++; $display("FAIL reset_conflict got %h exp 0000", conflict_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL reset_first_winner got %b exp 10", {m0_gnt, m1_gnt}); end
    idle();
    cyc();
  endtask

  task automatic test_contention();
    logic e0;
    logic p0;
    do_reset();
    use_model = 1'b1; mem_gnt_i = 1'b1;
    m0_addr = 22'h100; m1_addr = 22'h200; m0_we = 1'b0; m1_we = 1'b0;
    m0_be = 4'hF; m1_be = 4'hF;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      e0 = ((i % 2) == 0);
      checks++;
      if ({m0_gnt, m1_gnt} !== {e0, ~e0}) begin
        errors++; $display("FAIL contention_gnt cycle %0d got %b exp %b", i, {m0_gnt, m1_gnt}, {e0, ~e0});
      end
      if (i > 0) begin
        p0 = (((i - 1) % 2) == 0);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== {p0, ~p0} ||
            (p0 && m0_rdata !== 32'hA000_0040) || (!p0 && m1_rdata !== 32'hA000_0080)) begin
          errors++; $display("FAIL contention_resp cycle %0d got rv %b d0 %h d1 %h", i, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
        end
      end
      cyc();
    end
    idle();
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hA000_0080) begin
      errors++; $display("FAIL contention_last_resp got rv %b d1 %h exp 01 a0000080", {m0_rvalid, m1_rvalid}, m1_rdata);
    end
    checks++; if (conflict_cnt !== 16'd8) begin errors++; $display("FAIL contention_count got %0d exp 8", conflict_cnt); end
    cyc();
  endtask

  task automatic test_single_master();
    int gcnt, rvcnt, m0_bad;
    do_reset();
    use_model = 1'b1; mem_gnt_i = 1'b1;
    gcnt = 0; rvcnt = 0; m0_bad = 0;
    m1_we = 1'b1; m1_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        m1_req = 1'b1; m1_addr = 22'h40 + 22'(4 * k); m1_wdata = 32'h1111_0000 + k;
      end else begin
        m1_req = 1'b0;
      end
      #1;
      if (m1_gnt === 1'b1) gcnt++;
      if (m1_rvalid === 1'b1) rvcnt++;
      if (m0_gnt !== 1'b0 || m0_rvalid !== 1'b0) m0_bad++;
      cyc();
    end
    checks++; if (gcnt != 4) begin errors++; $display("FAIL single_write_gnts got %0d exp 4", gcnt); end
    checks++; if (rvcnt != 4) begin errors++; $display("FAIL single_write_rvalids got %0d exp 4", rvcnt); end
    m1_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        m1_req = 1'b1; m1_addr = 22'h40 + 22'(4 * k);
      end else begin
        m1_req = 1'b0;
      end
      #1;
      if (m0_gnt !== 1'b0 || m0_rvalid !== 1'b0) m0_bad++;
      if (k > 0) begin
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== (32'h1111_0000 + k - 1)) begin
          errors++; $display("FAIL single_readback %0d got rv %b data %h exp 1 %h", k - 1, m1_rvalid, m1_rdata, 32'h1111_0000 + k - 1);
        end
      end
      cyc();
    end
    checks++; if (m0_bad != 0) begin errors++; $display("FAIL single_m0_quiet got %0d active cycles exp 0", m0_bad); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL single_conflict got %0d exp 0", conflict_cnt); end
  endtask

  task automatic test_full_fifo();
    logic [7:0] e_req, e_g0, e_g1, rv_in, e_rv0, e_rv1;
    e_req = 8'b0110_0011; e_g0 = 8'b0010_0001; e_g1 = 8'b0100_0010;
    rv_in = 8'b0011_0000; e_rv0 = 8'b0001_0000; e_rv1 = 8'b0010_0000;
    do_reset();
    use_model = 1'b0; mem_gnt_i = 1'b1;
    m0_we = 1'b0; m1_we = 1'b0; m0_addr = 22'h10; m1_addr = 22'h20;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      man_rvalid = rv_in[c];
      man_rdata  = 32'hD000_0000 + c;
      #1;
      checks++;
      if ({mem_req_o, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== {e_req[c], e_g0[c], e_g1[c], e_rv0[c], e_rv1[c]}) begin
        errors++; $display("FAIL full_cycle %0d got req/g0/g1/rv0/rv1 %b exp %b", c,
          {mem_req_o, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, {e_req[c], e_g0[c], e_g1[c], e_rv0[c], e_rv1[c]});
      end
      cyc();
    end
    idle();
    #1;
    checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL full_conflict got %0d exp 4", conflict_cnt); end
    cyc();
  endtask

  task automatic test_spurious();
    do_reset();
    use_model = 1'b0;
    man_rvalid = 1'b1;
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL spurious_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
    cyc();
    man_rvalid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spurious_err got %b exp 1", err); end
    cyc();
    cyc();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spurious_sticky got %b exp 1", err); end
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL spurious_cleared got %b exp 0", err); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    use_model = 1'b0; mem_gnt_i = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (65534) cyc();
    #1;
    checks++; if (conflict_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h exp fffe", conflict_cnt); end
    cyc();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", conflict_cnt); end
    cyc();
    cyc();
    checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", conflict_cnt); end
    m1_req = 1'b0; mem_gnt_i = 1'b1;
    cyc();
    idle();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    checks++; if (conflict_cnt !== 16'h0000) begin errors++; $display("FAIL midreset_conflict got %h exp 0000", conflict_cnt); end
    man_rvalid = 1'b1;
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL midreset_stale_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
    cyc();
    man_rvalid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL midreset_stale_err got %b exp 1", err); end
  endtask

  initial begin
    rst_i = 1'b1; mdl_init = 1'b1; use_model = 1'b0; mem_gnt_i = 1'b1;
    man_rvalid = 1'b0; man_rdata = 32'h0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 22'h0; m1_addr = 22'h0; m0_be = 4'hF; m1_be = 4'hF;
    m0_wdata = 32'h0; m1_wdata = 32'h0;
    cyc();
    mdl_init = 1'b0;
    test_reset();
    test_contention();
    test_single_master();
    test_full_fifo();
    test_spurious();
    test_saturation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
